// File: rtl/mul_sched.sv
// Round-robin scheduler sharing one multi-cycle multiplier among NUM_REQ requesters.
// Holds operands across the operation, masks stale done, enforces a timeout and per-owner flush.
module mul_sched #(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = 32,
  parameter int SKIP    = 2,
  parameter int TIMEOUT = 64
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic [NUM_REQ-1:0]        i_req_valid,
  output logic [NUM_REQ-1:0]        o_req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] i_req_a,
  input  logic [NUM_REQ*DATA_W-1:0] i_req_b,
  input  logic [NUM_REQ-1:0]        i_flush,
  output logic [NUM_REQ-1:0]        o_resp_valid,
  output logic [DATA_W-1:0]         o_resp_result,
  output logic                      o_resp_timeout,
  output logic                      o_busy,
  output logic                      o_mul_valid,
  output logic [DATA_W-1:0]         o_mul_a,
  output logic [DATA_W-1:0]         o_mul_b,
  input  logic                      i_mul_valid,
  input  logic [DATA_W-1:0]         i_mul_result,
  output logic [1:0]                o_dbg_state
);

  localparam int IW = (NUM_REQ > 2) ? 2 : 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  logic [1:0]         state;
  logic [IW-1:0]      rr_ptr;
  logic [IW-1:0]      owner;
  logic               cancel;
  logic               timeout_flag;
  logic [TW-1:0]      timer;

  logic [NUM_REQ-1:0] req_set;
  logic [NUM_REQ-1:0] grant_oh;
  logic [IW-1:0]      grant_idx;
  logic               grant_found;
  logic               cancel_now;

  // Round-robin search upward from rr_ptr with wrap-around; flushed requesters are not eligible.
  always_comb begin
    int idx;
    req_set     = i_req_valid & ~i_flush;
    grant_oh    = '0;
    grant_idx   = '0;
    grant_found = 1'b0;
    idx         = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = (int'(rr_ptr) + i) % NUM_REQ;
      if (!grant_found && req_set[idx]) begin
        grant_found   = 1'b1;
        grant_idx     = IW'(idx);
        grant_oh[idx] = 1'b1;
      end
    end
  end

  // Handshake: requester k transfers its operands on the rising edge where
  // i_req_valid[k] & o_req_ready[k] is 1. Ready is a one-hot grant offered only
  // in IDLE; a requester keeps valid and operands stable until it sees ready.
  // Responses are single-cycle pushes (o_resp_valid) with no back-pressure.
  assign o_req_ready = (state == ST_IDLE && i_rst_n) ? grant_oh : '0;

  // A flush arriving in the response cycle must still suppress that response.
  assign cancel_now = cancel | i_flush[owner];

  always_comb begin
    o_resp_valid = '0;
    if (state == ST_RESP && !cancel_now) o_resp_valid[owner] = 1'b1;
  end

  assign o_resp_timeout = (state == ST_RESP) && !cancel_now && timeout_flag;
  assign o_mul_valid    = (state == ST_ISSUE);
  assign o_busy         = (state != ST_IDLE);
  assign o_dbg_state    = state;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state         <= ST_IDLE;
      rr_ptr        <= '0;
      owner         <= '0;
      cancel        <= 1'b0;
      timeout_flag  <= 1'b0;
      timer         <= '0;
      o_resp_result <= '0;
      o_mul_a       <= '0;
      o_mul_b       <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (grant_found) begin
            o_mul_a <= i_req_a[int'(grant_idx)*DATA_W +: DATA_W];
            o_mul_b <= i_req_b[int'(grant_idx)*DATA_W +: DATA_W];
            owner   <= grant_idx;
            cancel  <= 1'b0;
            rr_ptr  <= (grant_idx == IW'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
            state   <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          timer <= '0;
          if (i_flush[owner]) cancel <= 1'b1;
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          timer <= timer + 1'b1;
          if (i_flush[owner]) cancel <= 1'b1;
          // The first SKIP cycles may still see done held from the previous operation.
          if (i_mul_valid && timer >= TW'(SKIP)) begin
            o_resp_result <= i_mul_result;
            timeout_flag  <= 1'b0;
            state         <= ST_RESP;
          end else if (timer == TW'(TIMEOUT - 1)) begin
            o_resp_result <= '0;
            timeout_flag  <= 1'b1;
            state         <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (i_flush[owner]) cancel <= 1'b1;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/mul_sched.md
Name: mul_sched

Overview:
Scheduler that shares one multi-cycle integer multiplier among NUM_REQ requesters (e.g. the integer execute stage and the address-generation path) inside the ALU cluster. Performs round-robin arbitration with a valid/ready handshake per requester. Issues a one-cycle start to the multiplier and holds the operands stable until the multiplier reports completion. Routes the result back to the originating requester, with stale-done masking, a completion timeout and per-requester flush.

Parameters:
NUM_REQ, 2, number of requesters (2..4)
DATA_W, 32, operand/result width
SKIP, 2, WAIT cycles during which i_mul_valid is ignored (stale-done guard)
TIMEOUT, 64, max WAIT cycles before forced timeout response

Ports:
i_clk  in  1  clock, rising edge
i_rst_n  in  1  reset, asynchronous, active-low
i_req_valid  in  NUM_REQ  per-requester request valid
o_req_ready  out  NUM_REQ  one-hot grant; a transfer occurs when valid&ready
i_req_a  in  NUM_REQ*DATA_W  operand A, requester k at slice [k*DATA_W +: DATA_W]
i_req_b  in  NUM_REQ*DATA_W  operand B, same packing
i_flush  in  NUM_REQ  cancel the response of requester k
o_resp_valid  out  NUM_REQ  one-cycle response pulse to the owning requester
o_resp_result  out  DATA_W  result, valid with o_resp_valid
o_resp_timeout  out  1  response was forced by timeout; o_resp_result is 0
o_busy  out  1  high in any state other than IDLE
o_mul_valid  out  1  one-cycle start pulse to the multiplier
o_mul_a  out  DATA_W  operand A to the multiplier, registered
o_mul_b  out  DATA_W  operand B to the multiplier, registered
i_mul_valid  in  1  multiplier done; may stay high after completion
i_mul_result  in  DATA_W  multiplier result

Behaviour:
- Reset (async, i_rst_n=0):
  - state=IDLE, rr_ptr=0, owner=0, cancel=0, timer=0.
  - All outputs are 0: o_req_ready, o_resp_valid, o_resp_result, o_resp_timeout, o_mul_valid, o_mul_a, o_mul_b, o_busy.
  - Reset mid-transaction drops the transaction silently; no response is produced.
- State machine: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
- IDLE:
  - Request set = i_req_valid & ~i_flush.
  - If non-empty, grant the first set bit searching upward from rr_ptr with wrap-around.
  - o_req_ready = grant one-hot, combinational, IDLE only; all zeros in every other state.
  - On the grant edge: latch that requester's operands into o_mul_a/o_mul_b, set owner=grant, cancel=0, rr_ptr=(grant+1) mod NUM_REQ, go to ISSUE.
  - With no request, stay in IDLE.
- ISSUE:
  - o_mul_valid=1 for exactly this cycle. Clear timer. Go to WAIT.
- WAIT:
  - timer increments every cycle.
  - i_mul_valid is ignored while timer < SKIP.
  - If i_mul_valid=1 and timer >= SKIP: register i_mul_result into o_resp_result, set timeout flag=0, go to RESP.
  - Else if timer == TIMEOUT-1: set o_resp_result=0 and timeout flag=1, go to RESP.
  - Done and timeout in the same cycle: done wins.
- RESP:
  - o_resp_valid[owner]=1 and o_resp_timeout=flag for one cycle, unless cancel=1, in which case no pulse.
  - Go to IDLE; a new grant is possible the following cycle.
- Operand hold: o_mul_a and o_mul_b stay stable from ISSUE through RESP and change only on the next grant.
- Flush:
  - i_flush[owner]=1 in any of ISSUE, WAIT or RESP sets cancel (sticky until the next grant).
  - Cancellation in RESP takes effect that same cycle, so the pulse is suppressed.
  - The multiplier cannot be aborted, so the transaction still runs to completion or timeout.
  - i_flush[k] has no effect on other owners.
- Output hold:
  - o_resp_result holds its value until overwritten.
  - o_resp_valid and o_mul_valid are single-cycle pulses.
- Latency: grant cycle T; o_mul_valid at T+1; response at done+1 cycle. Minimum T+SKIP+3.
- Throughput: at most one transaction in flight; o_busy=1 blocks all grants.

Test Plan:
1. Single request: req0 A=7, B=6; model multiplier with 31-cycle latency. Expect ready[0] at T, o_mul_valid at T+1, one resp_valid[0] pulse with result 42 and timeout=0.
2. Fairness: both requesters hold valid, 4 transactions (A=k+1, B=3). Expect grant order 0,1,0,1 and results 3,6,9,12 each routed to the correct requester.
3. Stale done: model holds i_mul_valid=1 with result 99 from a prior op for 2 cycles after start, true result 15 (5x3) later. Expect 15 delivered, never 99.
4. Timeout: multiplier never asserts done. Expect resp_valid pulse exactly TIMEOUT=64 WAIT cycles after entering WAIT, result 0, timeout=1, then the scheduler returns to IDLE.
5. Flush: flush[0] pulsed mid-WAIT. Expect no resp_valid for requester 0; a pending req1 (A=-4, B=5) is served next with result -20 (0xFFFFFFEC).
6. Reset mid-WAIT: assert i_rst_n=0 for 1 cycle. Expect all outputs 0 asynchronously, no response, and rr_ptr=0, so req0 wins on the next simultaneous request.
